// File: rtl/aux_write_scheduler.sv
// Buffers CPU writes to an auxiliary memory and issues them, or a full-memory clear,
// only while the display is blanked.
module aux_write_scheduler #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned AUX_ADDRESS_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         cpu_wr_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] cpu_address_in,
    input  logic [DATA_WIDTH-1:0]        cpu_data_in,
    output logic                         cpu_ready_out,
    input  logic                         clear_in,
    input  logic                         blank_in,
    output logic                         memory_wr_out,
    output logic [AUX_ADDRESS_WIDTH-1:0] write_address_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         busy_out,
    output logic                         drop_error_out
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = AUX_ADDRESS_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ENTRY_W-1:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [CNT_W-1:0]             count;
    logic                         clear_pending;
    logic [AUX_ADDRESS_WIDTH-1:0] clear_counter;

    logic push;
    logic pop;
    logic clear_write;
    logic clear_done;
    logic fifo_empty;
    logic last_addr;

    assign fifo_empty    = (count == '0);
    assign cpu_ready_out = (count < CNT_W'(FIFO_DEPTH));
    assign push          = cpu_wr_in && cpu_ready_out;
    assign busy_out      = !fifo_empty || clear_pending;
    assign last_addr     = (clear_counter == '1);
    assign clear_done    = clear_write && last_addr;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pending clear always wins the write slot over buffered CPU writes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (blank_in) begin
                    if (clear_pending) begin
                        state_next = CLEAR;
                    end else if (!fifo_empty) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!blank_in) begin
                    state_next = IDLE;
                end else if (clear_pending) begin
                    state_next = CLEAR;
                end else if (fifo_empty) begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (blank_in && last_addr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        clear_write = 1'b0;
        case (state)
            IDLE, DRAIN: begin
                if (blank_in) begin
                    if (clear_pending) begin
                        clear_write = 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end
                end
            end
            CLEAR:   clear_write = blank_in;
            default: ;
        endcase
    end

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cpu_address_in, cpu_data_in};
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            clear_pending     <= 1'b0;
            clear_counter     <= '0;
            drop_error_out    <= 1'b0;
            memory_wr_out     <= 1'b0;
            write_address_out <= '0;
            data_out          <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (cpu_wr_in && !cpu_ready_out) begin
                drop_error_out <= 1'b1;
            end

            if (clear_done) begin
                clear_pending <= 1'b0;
            end else if (clear_in) begin
                clear_pending <= 1'b1;
            end

            if (clear_write) begin
                clear_counter <= clear_done ? '0 : clear_counter + 1'b1;
            end

            memory_wr_out <= pop || clear_write;
            if (pop) begin
                {write_address_out, data_out} <= fifo_mem[rd_ptr];
            end else if (clear_write) begin
                write_address_out <= clear_counter;
                data_out          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aux_write_scheduler.sv
// Random and directed stimulus against a rule-level model; expected memory writes are
// queued by the model and matched by an independent monitor.
module tb_aux_write_scheduler;

    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NWORDS = 32;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          cpu_wr_in;
    logic [AW-1:0] cpu_address_in;
    logic [DW-1:0] cpu_data_in;
    logic          cpu_ready_out;
    logic          clear_in;
    logic          blank_in;
    logic          memory_wr_out;
    logic [AW-1:0] write_address_out;
    logic [DW-1:0] data_out;
    logic          busy_out;
    logic          drop_error_out;

    aux_write_scheduler #(
        .DATA_WIDTH(DW),
        .AUX_ADDRESS_WIDTH(AW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock_in(clk),
        .reset_in(reset_in),
        .cpu_wr_in(cpu_wr_in),
        .cpu_address_in(cpu_address_in),
        .cpu_data_in(cpu_data_in),
        .cpu_ready_out(cpu_ready_out),
        .clear_in(clear_in),
        .blank_in(blank_in),
        .memory_wr_out(memory_wr_out),
        .write_address_out(write_address_out),
        .data_out(data_out),
        .busy_out(busy_out),
        .drop_error_out(drop_error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    wr_t  exp_q[$];
    req_t m_fifo[$];
    bit   m_pend;
    int   m_idx;
    bit   m_drop;
    bit   m_rst;
    bit   m_ready_before;
    bit   m_pend_before;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: each blanked edge carries one write; a pending clear owns it, else the oldest buffered request.
    always @(posedge clk) begin
        req_t r;
        cyc++;
        m_rst = reset_in;
        if (reset_in) begin
            m_fifo.delete();
            m_pend = 1'b0;
            m_idx  = 0;
            m_drop = 1'b0;
        end else begin
            m_ready_before = (m_fifo.size() < DEPTH);
            m_pend_before  = m_pend;
            if (blank_in) begin
                if (m_pend) begin
                    exp_q.push_back('{cyc, AW'(m_idx), '0});
                    if (m_idx == NWORDS - 1) begin
                        m_pend = 1'b0;
                        m_idx  = 0;
                    end else begin
                        m_idx++;
                    end
                end else if (m_fifo.size() > 0) begin
                    r = m_fifo.pop_front();
                    exp_q.push_back('{cyc, r.a, r.d});
                end
            end
            if (cpu_wr_in) begin
                if (m_ready_before) m_fifo.push_back('{cpu_address_in, cpu_data_in});
                else m_drop = 1'b1;
            end
            if (clear_in && !m_pend_before) m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (cyc > 0) begin
            if (m_rst) begin
                chk("reset_addr", 32'(write_address_out), 32'd0);
                chk("reset_data", 32'(data_out), 32'd0);
            end
            chk("ready", 32'(cpu_ready_out), 32'(m_fifo.size() < DEPTH));
            chk("busy", 32'(busy_out), 32'((m_fifo.size() != 0) || m_pend));
            chk("drop_error", 32'(drop_error_out), 32'(m_drop));
            if (memory_wr_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 32'(memory_wr_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_edge", 32'(cyc), 32'(e.cyc));
                    chk("write_addr", 32'(write_address_out), 32'(e.a));
                    chk("write_data", 32'(data_out), 32'(e.d));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_write", 32'(memory_wr_out), 32'd1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_wr_in      = 1'b1;
        cpu_address_in = a;
        cpu_data_in    = d;
        step(1);
        cpu_wr_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        step(1);
        clear_in = 1'b0;
    endtask

    initial begin
        reset_in       = 1'b1;
        cpu_wr_in      = 1'b0;
        cpu_address_in = '0;
        cpu_data_in    = '0;
        clear_in       = 1'b0;
        blank_in       = 1'b1;
        step(2);
        reset_in = 1'b0;
        step(1);

        // single write with minimum latency
        push(AW'(3), 16'h000F);
        step(3);

        // overflow while display active, then drain in order
        blank_in = 1'b0;
        for (int i = 0; i < 5; i++) push(AW'(i + 10), DW'(16'h0100 + i));
        step(3);
        blank_in = 1'b1;
        step(8);

        // full clear
        pulse_clear();
        step(40);

        // clear interrupted by active display at address 12
        pulse_clear();
        step(12);
        blank_in = 1'b0;
        step(10);
        blank_in = 1'b1;
        step(30);

        // push during clear lands after the clear
        pulse_clear();
        step(5);
        push(AW'(7), 16'h00AA);
        step(40);

        // reset mid-drain drops queued entries
        blank_in = 1'b0;
        for (int i = 0; i < 4; i++) push(AW'(20 + i), DW'(16'h0200 + i));
        blank_in = 1'b1;
        step(1);
        reset_in = 1'b1;
        step(1);
        reset_in = 1'b0;
        step(6);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_wr_in      = ($urandom_range(0, 1) == 1);
            cpu_address_in = AW'($urandom);
            cpu_data_in    = DW'($urandom);
            clear_in       = ($urandom_range(0, 149) == 0);
            reset_in       = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 7) == 0) blank_in = ~blank_in;
            step(1);
        end
        cpu_wr_in = 1'b0;
        clear_in  = 1'b0;
        reset_in  = 1'b0;
        blank_in  = 1'b1;
        step(80);

        chk("pending_writes_left", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
